// File: rtl/stage_operand.sv
// ---------------------------------------------------------------------------
// stage_operand
//
// Operand-fetch stage between the instruction decoder and execute.
// Accepts cracked instructions over a valid/ready handshake and resolves the
// predicate (P), source A, B and M operands. Each operand comes from one of:
// r0 (constant zero), the register file with writeback bypass, one of NFWD
// prioritised forwarding ports, or the writeback port. A per-register
// scoreboard tracks destinations that have been issued but not yet written
// back. The stage stalls only while a needed pending source has no value
// available. An instruction whose predicate is false is consumed without
// issuing. Issuing a jump raises flush for exactly one cycle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready is combinational)
//   in_pc, in_ctrl            pc and opaque payload carried to the output
//   in_ra_p/a/b/m/d           predicate, source A/B/M and destination regs
//   in_pinv                   invert predicate sense
//   in_use_imm, in_imm        B operand taken from in_imm when set
//   in_jump                   instruction is a jump
//   wb_valid/addr/data        register writeback port
//   fwd_valid/addr/data       NFWD packed forwarding ports, port 0 highest
//   out_valid / out_ready     downstream handshake
//   out_pc/a/b/m/dest/ctrl    registered issued instruction
//   out_jump                  issued instruction is a jump
//   flush                     upstream must drop and redirect
// ---------------------------------------------------------------------------
module stage_operand #(
  parameter int XLEN  = 32,
  parameter int NREG  = 16,
  parameter int NFWD  = 2,
  parameter int CTRLW = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [XLEN-1:0]                 in_pc,
  input  logic [$clog2(NREG)-1:0]         in_ra_p,
  input  logic [$clog2(NREG)-1:0]         in_ra_a,
  input  logic [$clog2(NREG)-1:0]         in_ra_b,
  input  logic [$clog2(NREG)-1:0]         in_ra_m,
  input  logic [$clog2(NREG)-1:0]         in_ra_d,
  input  logic                            in_pinv,
  input  logic                            in_use_imm,
  input  logic [XLEN-1:0]                 in_imm,
  input  logic [CTRLW-1:0]                in_ctrl,
  input  logic                            in_jump,
  input  logic                            wb_valid,
  input  logic [$clog2(NREG)-1:0]         wb_addr,
  input  logic [XLEN-1:0]                 wb_data,
  input  logic [NFWD-1:0]                 fwd_valid,
  input  logic [NFWD*$clog2(NREG)-1:0]    fwd_addr,
  input  logic [NFWD*XLEN-1:0]            fwd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_pc,
  output logic [XLEN-1:0]                 out_a,
  output logic [XLEN-1:0]                 out_b,
  output logic [XLEN-1:0]                 out_m,
  output logic [$clog2(NREG)-1:0]         out_dest,
  output logic [CTRLW-1:0]                out_ctrl,
  output logic                            out_jump,
  output logic                            flush
);

  localparam int AW   = $clog2(NREG);
  localparam int NSRC = 4;
  // Source slot indices
  localparam int SP = 0;
  localparam int SA = 1;
  localparam int SB = 2;
  localparam int SM = 3;

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic [NREG-1:0] pending_set;
  logic [NREG-1:0] pending_clr;

  logic [AW-1:0]   src_addr [NSRC];
  logic [NSRC-1:0] src_need;
  logic [NSRC-1:0] src_ok;
  logic [XLEN-1:0] src_val  [NSRC];
  logic [NSRC-1:0] wb_hit;
  logic [XLEN-1:0] rf_val   [NSRC];
  logic [NFWD-1:0] fwd_match [NSRC];
  logic [NSRC-1:0] fwd_hit;
  logic [XLEN-1:0] fwd_val  [NSRC];

  logic            hazard;
  logic            accept;
  logic            pred;
  logic            issue;
  logic [XLEN-1:0] operand_b;

  // Collect source addresses and which sources this instruction needs.
  always_comb begin
    src_addr[SP] = in_ra_p;
    src_addr[SA] = in_ra_a;
    src_addr[SB] = in_ra_b;
    src_addr[SM] = in_ra_m;
    // B is only fetched from the register side when no immediate is used.
    src_need     = {1'b1, ~in_use_imm, 1'b1, 1'b1};
  end

  // Forward-port search per source; the reverse scan leaves the lowest matching port.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      fwd_val[s] = {XLEN{1'b0}};
      for (int f = 0; f < NFWD; f++) begin
        fwd_match[s][f] = fwd_valid[f] && (fwd_addr[f*AW +: AW] == src_addr[s]);
      end
      for (int f = NFWD - 1; f >= 0; f--) begin
        fwd_val[s] = fwd_match[s][f] ? fwd_data[f*XLEN +: XLEN] : fwd_val[s];
      end
      fwd_hit[s] = |fwd_match[s];
    end
  end

  // Register-file read with writeback bypass, then full source resolution.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      wb_hit[s] = wb_valid && (wb_addr == src_addr[s]);
      rf_val[s] = wb_hit[s] ? wb_data : rf[src_addr[s]];
      if (src_addr[s] == {AW{1'b0}}) begin
        src_ok[s]  = 1'b1;
        src_val[s] = {XLEN{1'b0}};
      end else if (!pending[src_addr[s]]) begin
        src_ok[s]  = 1'b1;
        src_val[s] = rf_val[s];
      end else if (fwd_hit[s]) begin
        src_ok[s]  = 1'b1;
        src_val[s] = fwd_val[s];
      end else if (wb_hit[s]) begin
        src_ok[s]  = 1'b1;
        src_val[s] = wb_data;
      end else begin
        src_ok[s]  = 1'b0;
        src_val[s] = {XLEN{1'b0}};
      end
    end
  end

  // Hazard, handshake, predication and issue decision.
  always_comb begin
    hazard    = |(src_need & ~src_ok);
    // During flush everything presented is accepted and dropped, so no stall.
    in_ready  = flush | (~hazard & (~out_valid | out_ready));
    accept    = in_valid & in_ready;
    pred      = (src_val[SP] == {XLEN{1'b0}}) ^ in_pinv;
    issue     = accept & pred & ~flush;
    operand_b = in_use_imm ? in_imm : src_val[SB];
  end

  // Scoreboard next state: set on issue beats clear on writeback; r0 never pending.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pending_set[r] = issue && (in_ra_d == AW'(r));
      pending_clr[r] = wb_valid && (wb_addr == AW'(r));
    end
    pending_next = (pending_set | (pending & ~pending_clr))
                 & ~{{(NREG-1){1'b0}}, 1'b1};
  end

  // Register file write port; r0 is never stored since reads of r0 return zero.
  always_ff @(posedge clk) begin
    if (wb_valid && (wb_addr != {AW{1'b0}})) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Scoreboard, flush pulse and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= {NREG{1'b0}};
      flush     <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= {XLEN{1'b0}};
      out_a     <= {XLEN{1'b0}};
      out_b     <= {XLEN{1'b0}};
      out_m     <= {XLEN{1'b0}};
      out_dest  <= {AW{1'b0}};
      out_ctrl  <= {CTRLW{1'b0}};
      out_jump  <= 1'b0;
    end else begin
      pending <= pending_next;
      // A jump leaving this stage redirects fetch in the same cycle it is presented.
      flush   <= issue & in_jump;
      if (issue) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_a     <= src_val[SA];
        out_b     <= operand_b;
        out_m     <= src_val[SM];
        out_dest  <= in_ra_d;
        out_ctrl  <= in_ctrl;
        out_jump  <= in_jump;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stage_operand.md
# stage_operand

Parametrised operand-fetch stage between the instruction decoder and execute. It accepts cracked instructions over a valid/ready handshake and tracks in-flight destinations with a per-register scoreboard. Source operands are resolved from the register file, a writeback port or NFWD prioritised forwarding ports, and the stage stalls only when a pending source is not yet available. It also applies register predication and issues a one-cycle flush after a jump, replacing the fixed-width, single-forward decode stage.

## Interface
- XLEN, 32, data/pc width
- NREG, 16, register count (power of two, ≥2); AW = clog2(NREG) is derived, not a parameter
- NFWD, 2, number of forwarding ports; port 0 has the highest priority
- CTRLW, 8, opaque control payload width passed through unchanged
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid / in_ready  in/out  1  upstream handshake
- in_pc  in  XLEN  instruction pc
- in_ra_p, in_ra_a, in_ra_b, in_ra_m, in_ra_d  in  AW each  predicate, source A/B/M and destination register
- in_pinv  in  1  predicate invert
- in_use_imm  in  1  B operand comes from in_imm
- in_imm  in  XLEN  pre-extended immediate
- in_ctrl  in  CTRLW  control payload
- in_jump  in  1  instruction is a jump
- wb_valid  in  1  writeback strobe
- wb_addr  in  AW  writeback register
- wb_data  in  XLEN  writeback value
- fwd_valid  in  NFWD  per-port forward valid
- fwd_addr  in  NFWD*AW  packed forward addresses, port i at [i*AW +: AW]
- fwd_data  in  NFWD*XLEN  packed forward data, port i at [i*XLEN +: XLEN]
- out_valid / out_ready  out/in  1  downstream handshake
- out_pc, out_a, out_b, out_m  out  XLEN  issued pc and operands
- out_dest  out  AW  destination register
- out_ctrl  out  CTRLW  payload
- out_jump  out  1  issued instruction is a jump
- flush  out  1  upstream must drop and redirect

## Operation
- **Register file:** NREG x XLEN. r0 always reads 0 and writes to r0 are ignored. A write on wb_valid takes effect at the clock edge. A same-cycle read of wb_addr returns wb_data (bypass).
- **Scoreboard:** one pending bit per register.
  - Set on issue of an instruction whose in_ra_d ≠ 0.
  - Cleared on wb_valid for wb_addr.
  - Simultaneous set and clear of the same register: set wins.
  - Bit 0 is never set.
- **Source resolution:** the needed sources are P, A and M, plus B when in_use_imm = 0. For each needed source, in priority order:
  - address 0 → 0;
  - not pending → register file, with wb bypass;
  - pending → lowest-index fwd port with fwd_valid and a matching address;
  - pending, no forward match → wb_data if wb_valid matches;
  - otherwise the source is unresolved.
- **hazard** = any needed source unresolved.
- **Handshake:**
  - in_ready = flush | (!hazard & (!out_valid | out_ready)).
  - accept = in_valid & in_ready.
- **Predication:** pred = (P == 0) XOR in_pinv.
  - An accepted instruction with pred = 0 is consumed silently: no output, no scoreboard set.
  - An accepted instruction while flush = 1 is dropped the same way.
- **Issue** = accept & pred & !flush. Issue loads all out_* registers and sets out_valid. out_b = in_imm when in_use_imm = 1.
- **Output register:**
  - out_valid with !out_ready holds every out_* bit stable.
  - out_valid & out_ready with no new issue clears out_valid.
- **Jump:** issue with in_jump = 1 sets flush for exactly the next cycle.

## Timing
- Reset values:
  - out_valid = 0, flush = 0, out_jump = 0;
  - out_pc / out_a / out_b / out_m / out_ctrl = 0, out_dest = 0;
  - scoreboard all clear;
  - register file contents (except r0) are undefined.
- Reset mid-operation discards the held output and all pending bits.
- Latency: accept → out_valid at the next edge. Throughput is 1 instruction/cycle with no hazard.
- Back-to-back dependent instructions: the consumer stalls until the producer's value appears on a fwd port or on wb. It issues in the cycle it appears.
- in_ready may depend combinationally on in_* and on fwd/wb inputs. It never depends on in_valid.
- flush coincides with the cycle in which out_valid first presents the jump.

## Test plan
- **Basic issue:** reset, then write r3 = 0x11 via wb; issue A=r3, B=imm 0x5, d=r4 → next cycle out_a = 0x11, out_b = 0x5, out_dest = 4, and pending[4] = 1.
- **Forward priority:** issue d=r4, then a consumer A=r4. Drive fwd0 = {r4, 0xAA} and fwd1 = {r4, 0xBB} in the same cycle → out_a = 0xAA. Without any forward, the consumer holds with in_ready = 0 until wb r4 = 0x77, then issues with out_a = 0x77 and pending[4] clears.
- **Downstream backpressure:** hold out_ready = 0 for 3 cycles with a second instruction waiting → out_* stable, in_ready = 0; the second instruction issues on the cycle after out_ready rises.
- **Predication:** r2 = 0 with pinv = 1 → instruction consumed, no out_valid, pending[d] = 0. r2 = 5 with pinv = 1 → issues.
- **Jump flush:** issue a jump, with the next instruction presented immediately → flush = 1 for one cycle and that instruction is dropped. The instruction after it issues normally.
- **Scoreboard corner cases:** issue d=r6 while wb r6 is active in the same cycle → pending[6] remains 1. Assert rst with out_valid = 1 → out_valid = 0 and all pending bits clear next cycle.
